logic_microop_unit: RTL and testbench
=====================================

# logic_microop_unit

Parametrised, registered logic/shift micro-operation unit with a valid/ready handshake on both sides. It extends the 4-bit combinational AND/OR/XOR/NOT logic unit to WIDTH bits and adds multi-cycle bit-serial shift and rotate micro-operations, a held output register, and zero/parity status flags. It sits between the register file read ports and the write-back path of the datapath.

## Interface
- WIDTH, 4, operand/result width; legal values ≥ 2.
- SHW, $clog2(WIDTH), derived localparam; shift-amount width.

- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit accepts a request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shift/rotate ops, b[SHW-1:0] is the shift amount n.
- sel  in  3  micro-op select.
- out_valid  out  1  f/zero/parity hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- f  out  WIDTH  registered result.
- zero  out  1  registered, (f == 0).
- parity  out  1  registered, XOR-reduction of f.
- busy  out  1  high while in SHIFT state.

## Operation
- sel encoding:
  - 000 AND: a & b
  - 001 OR: a | b
  - 010 XOR: a ^ b
  - 011 NOT: ~a, b ignored
  - 100 SHL: a << n, logical
  - 101 SHR: a >> n, logical
  - 110 ROL: a rotated left by n
  - 111 PASS: b
- Accept rule: a request is accepted on an edge where in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- States:
  - IDLE: accepting requests.
  - SHIFT: bit-serial work; a working register and a down-counter cnt (SHW bits) are live.
- Op types:
  - Single-cycle ops are 000–011 and 111, plus 100–110 when n == 0. On acceptance, f, zero and parity load the result and out_valid is set. The state stays IDLE.
  - Shift ops are 100–110 with n ≥ 1. On acceptance, work ← a, cnt ← n, the op is latched, and the state goes to SHIFT. out_valid is cleared if out_ready consumed the old result; otherwise it cannot be high, per the in_ready rule.
- SHIFT state, each edge:
  - work moves one bit: SHL zero-fills the LSB, SHR zero-fills the MSB, ROL moves the MSB into the LSB.
  - cnt decrements.
  - When cnt == 1: f ← shifted work, flags update, out_valid ← 1, state → IDLE.
- Output register: out_valid stays high, and f/zero/parity stay stable, until an edge with out_ready high. On that edge out_valid clears, unless a new single-cycle request is accepted on the same edge, in which case the new result loads and out_valid stays 1.
- n is taken modulo WIDTH via b[SHW-1:0]. For non-power-of-2 WIDTH, any n ≥ WIDTH is clamped to WIDTH−1.
- Inputs a, b and sel are sampled only on the accepting edge. Later changes have no effect.

## Timing
- Reset (rst_n low on an edge) gives: state IDLE, f = 0, zero = 1, parity = 0, out_valid = 0, busy = 0, cnt = 0. While held in reset, in_ready = 1 from the first cycle after the reset edge.
- Single-cycle op accepted at edge k: out_valid = 1 and f valid after edge k. Latency 1.
- Shift op with n ≥ 1 accepted at edge k:
  - busy is high after edges k .. k+n−1.
  - The result appears after edge k+n. Latency n+1.
  - in_ready is 0 throughout.
- Throughput: single-cycle ops sustain one per cycle when out_ready is held high.
- Reset mid-SHIFT: the partial result is discarded, no out_valid pulse occurs, and all outputs take their reset values.
- Simultaneous in_valid and out_ready while out_valid: both the consume and the accept occur on the same edge, with no bubble.
- in_valid while busy: ignored, because in_ready = 0. The request must be held by the producer.

## Test plan
- WIDTH=4, a=1010, b=1100: sel 000/001/010/011, each with out_ready=1 → f = 1000 / 1110 / 0110 / 0101, one per cycle, with parity 1/1/0/0.
- WIDTH=4, SHL a=0011, b=0010: f=1100 after the 3rd edge. busy is high for 2 cycles and in_ready stays 0 until completion. Next, ROL a=1001, n=3 → f=1100.
- Backpressure: a result is pending with out_ready=0 for 5 cycles → f stays stable, out_valid stays 1, in_ready stays 0. Raising out_ready along with in_valid (XOR 1111^1111) → f=0000, zero=1, out_valid stays 1.
- Reset mid-shift: SHR a=1000, n=3, with rst_n low after the 1st shift edge → after the reset edge, out_valid=0, f=0000, zero=1, busy=0, in_ready=1. No result is emitted later.
- n=0 shift: SHL a=0110, b=0000 → f=0110 with latency 1 and busy never asserted.
- WIDTH=8: ROL a=10000001, b=00000111 → f=11000000 after 8 edges. Also PASS b=00000000 → zero=1, parity=0.

Source files
------------

// File: rtl/logic_microop_unit.sv
// logic_microop_unit
//   Registered WIDTH-bit logic/shift micro-op unit with valid/ready on both
//   sides. Bitwise ops and PASS complete in one cycle. SHL/SHR/ROL with n >= 1
//   run bit-serially, one bit per cycle, in the SHIFT state.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake (a, b, sel sampled on accept)
//   a, b, sel           operands and micro-op select; b[SHW-1:0] is shift amount
//   out_valid/out_ready result handshake
//   f, zero, parity     held result register and its status flags
//   busy                high while a bit-serial shift is in progress
module logic_microop_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             parity,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             out_valid_q, out_valid_d;

  logic [SHW-1:0]   n_raw, n_eff;
  logic             accept, single_op;
  logic [WIDTH-1:0] res, shifted;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign busy      = (state_q == SHIFT);

  // Shift amount: the low SHW bits of b; for non-power-of-2 WIDTH the
  // out-of-range codes saturate at WIDTH-1.
  always_comb begin
    n_raw = b[SHW-1:0];
    n_eff = n_raw;
    if ({1'b0, n_raw} > (SHW+1)'(WIDTH-1)) n_eff = SHW'(WIDTH-1);
  end

  // Shift ops with n == 0 degrade to a pass of a, so they finish in one cycle.
  assign single_op = !sel[2] || (sel == 3'b111) || (n_eff == '0);

  always_comb begin
    res = a;
    case (sel)
      3'b000:  res = a & b;
      3'b001:  res = a | b;
      3'b010:  res = a ^ b;
      3'b011:  res = ~a;
      3'b111:  res = b;
      default: res = a;
    endcase
  end

  always_comb begin
    shifted = work_q;
    case (op_q)
      OP_SHL:  shifted = {work_q[WIDTH-2:0], 1'b0};
      OP_SHR:  shifted = {1'b0, work_q[WIDTH-1:1]};
      OP_ROL:  shifted = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    f_d         = f_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    out_valid_d = out_valid_q;

    // Consume first; a same-edge single-cycle accept below re-sets it.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (single_op) begin
            f_d         = res;
            zero_d      = (res == '0);
            parity_d    = ^res;
            out_valid_d = 1'b1;
          end else begin
            work_d  = a;
            cnt_d   = n_eff;
            op_d    = sel[1:0];
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          f_d         = shifted;
          zero_d      = (shifted == '0);
          parity_d    = ^shifted;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      op_q        <= OP_SHL;
      f_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      f_q         <= f_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_logic_microop_unit.sv
module tb_logic_microop_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // WIDTH=4 instance
  logic       in_valid = 0, in_ready, out_valid, out_ready = 0, zero, parity, busy;
  logic [3:0] a = 0, b = 0, f;
  logic [2:0] sel = 0;
  logic_microop_unit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .zero(zero), .parity(parity), .busy(busy));

  // WIDTH=8 instance
  logic       iv8 = 0, ir8, ov8, or8 = 1, z8, p8, bz8;
  logic [7:0] a8 = 0, b8 = 0, f8;
  logic [2:0] s8 = 0;
  logic_microop_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .sel(s8), .out_valid(ov8), .out_ready(or8),
    .f(f8), .zero(z8), .parity(p8), .busy(bz8));

  // WIDTH=5 instance: exercises shift-amount saturation
  logic       iv5 = 0, ir5, ov5, or5 = 1, z5, p5, bz5;
  logic [4:0] a5 = 0, b5 = 0, f5;
  logic [2:0] s5 = 0;
  logic_microop_unit #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5),
    .a(a5), .b(b5), .sel(s5), .out_valid(ov5), .out_ready(or5),
    .f(f5), .zero(z5), .parity(p5), .busy(bz5));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference: result of a 4-bit micro-op from its arithmetic definition.
  function automatic logic [3:0] ref_f(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y);
    int n = int'(y[1:0]);
    int v = int'(x);
    int r;
    case (s)
      3'd0: r = int'(x & y);
      3'd1: r = int'(x | y);
      3'd2: r = int'(x ^ y);
      3'd3: r = 15 - v;
      3'd4: r = (v * (1 << n)) % 16;
      3'd5: r = v / (1 << n);
      3'd6: r = ((v * (1 << n)) % 16) + (v / (1 << (4 - n))) % 16;
      default: r = int'(y);
    endcase
    return 4'(r);
  endfunction

  function automatic int ref_lat(input logic [2:0] s, input logic [3:0] y);
    return (s >= 3'd4 && s <= 3'd6) ? int'(y[1:0]) : 0;
  endfunction

  typedef struct {
    logic [2:0] sel;
    logic [3:0] a, b, f;
    logic       zero, parity;
  } vec_t;

  typedef struct {
    logic [3:0] f;
    int         acc;
    int         lat;
  } exp_t;

  initial begin
    vec_t vt[7];
    exp_t q[$];
    bit   seen, held, draining, busy_e, ov_e;
    int   steps;

    vt[0] = '{3'b000, 4'b1010, 4'b1100, 4'b1000, 1'b0, 1'b1};
    vt[1] = '{3'b001, 4'b1010, 4'b1100, 4'b1110, 1'b0, 1'b1};
    vt[2] = '{3'b010, 4'b1010, 4'b1100, 4'b0110, 1'b0, 1'b0};
    vt[3] = '{3'b011, 4'b1010, 4'b1100, 4'b0101, 1'b0, 1'b0};
    vt[4] = '{3'b111, 4'b1010, 4'b1100, 4'b1100, 1'b0, 1'b0};
    vt[5] = '{3'b100, 4'b0110, 4'b0000, 4'b0110, 1'b0, 1'b0};
    vt[6] = '{3'b101, 4'b1011, 4'b0100, 4'b1011, 1'b0, 1'b1};

    // Reset
    step(); step();
    chk("rst_f", f, 0); chk("rst_zero", zero, 1); chk("rst_par", parity, 0);
    chk("rst_ov", out_valid, 0); chk("rst_busy", busy, 0); chk("rst_rdy", in_ready, 1);
    rst_n = 1;
    step();

    // Single-cycle table, back to back
    out_ready = 1;
    foreach (vt[i]) begin
      in_valid = 1; sel = vt[i].sel; a = vt[i].a; b = vt[i].b;
      #1 chk("tbl_rdy", in_ready, 1);
      step();
      chk("tbl_f", f, vt[i].f); chk("tbl_zero", zero, vt[i].zero);
      chk("tbl_par", parity, vt[i].parity); chk("tbl_ov", out_valid, 1);
      chk("tbl_busy", busy, 0);
    end

    // SHL 0011 by 2
    sel = 3'b100; a = 4'b0011; b = 4'b0010;
    step(); in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      chk("shl_busy", busy, 1); chk("shl_rdy", in_ready, 0); chk("shl_ov", out_valid, 0);
      step();
    end
    chk("shl_f", f, 4'b1100); chk("shl_ov_done", out_valid, 1); chk("shl_busy_done", busy, 0);

    // ROL 1001 by 3
    in_valid = 1; sel = 3'b110; a = 4'b1001; b = 4'b0011;
    step(); in_valid = 0; a = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      chk("rol_busy", busy, 1); step();
    end
    chk("rol_f", f, 4'b1100); chk("rol_ov", out_valid, 1);

    // Backpressure, then consume + accept on the same edge
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_f", f, 4'b1100); chk("bp_ov", out_valid, 1); chk("bp_rdy", in_ready, 0);
    end
    in_valid = 1; sel = 3'b010; a = 4'b1111; b = 4'b1111; out_ready = 1;
    #1 chk("bp_rdy_up", in_ready, 1);
    step();
    chk("bp_f_new", f, 4'b0000); chk("bp_zero", zero, 1); chk("bp_ov_new", out_valid, 1);

    // Reset in the middle of SHR 1000 by 3
    sel = 3'b101; a = 4'b1000; b = 4'b0011;
    step(); in_valid = 0;
    step();
    rst_n = 0;
    step();
    chk("mrst_ov", out_valid, 0); chk("mrst_f", f, 0); chk("mrst_zero", zero, 1);
    chk("mrst_busy", busy, 0); chk("mrst_rdy", in_ready, 1);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step(); chk("mrst_no_out", out_valid, 0);
    end

    // WIDTH=8: ROL 10000001 by 7, then PASS 0
    iv8 = 1; s8 = 3'b110; a8 = 8'b10000001; b8 = 8'b00000111;
    steps = 0;
    step(); iv8 = 0; steps = 1;
    while (!ov8 && steps < 20) begin
      step(); steps++;
    end
    chk("w8_edges", steps, 8); chk("w8_f", f8, 8'b11000000);
    iv8 = 1; s8 = 3'b111; b8 = 8'h00;
    step(); iv8 = 0;
    chk("w8_pass_zero", z8, 1); chk("w8_pass_par", p8, 0); chk("w8_pass_f", f8, 0);

    // WIDTH=5: n codes 7 and 5 saturate to 4
    iv5 = 1; s5 = 3'b100; a5 = 5'b00001; b5 = 5'b00111;
    steps = 0;
    step(); iv5 = 0; steps = 1;
    while (!ov5 && steps < 20) begin
      step(); steps++;
    end
    chk("w5_shl_edges", steps, 5); chk("w5_shl_f", f5, 5'b10000);
    iv5 = 1; s5 = 3'b110; a5 = 5'b00011; b5 = 5'b00101;
    steps = 0;
    step(); iv5 = 0; steps = 1;
    while (!ov5 && steps < 20) begin
      step(); steps++;
    end
    chk("w5_rol_edges", steps, 5); chk("w5_rol_f", f5, 5'b10001);

    // Randomized traffic against the reference model
    seen = 0; held = 0;
    out_ready = 0; in_valid = 0;
    step();
    for (int it = 0; it < 440; it++) begin
      step();
      if (q.size() > 0 && !seen && out_valid) begin
        chk("rnd_lat", cyc - q[0].acc, q[0].lat);
        chk("rnd_f", f, q[0].f);
        chk("rnd_zero", zero, q[0].f == 0);
        chk("rnd_par", parity, ^q[0].f);
        seen = 1;
      end
      busy_e = q.size() > 0 && !seen;
      ov_e   = q.size() > 0 && seen;
      chk("rnd_ov", out_valid, ov_e);
      chk("rnd_busy", busy, busy_e);
      draining = (it >= 400);
      out_ready = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!held) begin
        sel = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
        held = !draining && ($urandom_range(0, 2) != 0);
      end
      in_valid = held;
      #1;
      chk("rnd_rdy", in_ready, !busy_e && (!ov_e || out_ready));
      if (ov_e && out_ready) begin
        void'(q.pop_front());
        seen = 0;
      end
      if (in_valid && in_ready) begin
        q.push_back('{ref_f(sel, a, b), cyc + 1, ref_lat(sel, b)});
        held = 0;
      end
    end
    chk("rnd_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
